// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block type, FSM states, rcon table and the
// GF(2^8) byte substitution used by the round stages.
package aes_pkg;

  localparam int unsigned AES_ROUNDS = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [7:0] idx);
    case (idx)
      8'd1:    return 8'h01;
      8'd2:    return 8'h02;
      8'd3:    return 8'h04;
      8'd4:    return 8'h08;
      8'd5:    return 8'h10;
      8'd6:    return 8'h20;
      8'd7:    return 8'h40;
      8'd8:    return 8'h80;
      8'd9:    return 8'h1b;
      8'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit legal_unroll(input int unsigned u);
    return (u == 1) || (u == 2) || (u == 5) || (u == 10);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One combinational AES encryption round plus the matching key-schedule step.
module aes_round_stage
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  block_t             state,
  input  block_t             key_in,
  input  logic [CNT_W-1:0]   round,
  input  logic               is_last,
  output block_t             next_state,
  output block_t             next_key
);

  logic [31:0] w0, w1, w2, w3, tw, n0, n1, n2, n3;
  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];

  assign {w0, w1, w2, w3} = key_in;
  assign tw       = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(8'(round)), 24'h000000};
  assign n0       = w0 ^ tw;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Byte i lives at bits [127-8i -: 8]; byte index = row + 4*column.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign next_state[127-8*i -: 8] = (is_last ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: UNROLL rounds per clock, on-the-fly key
// schedule, valid/ready handshakes, exports the round-10 key for decryption.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic [127:0] out_last_key,
  output logic         busy
);

  if (!legal_unroll(UNROLL)) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end
  if (CNT_W < 4) begin : g_bad_cnt_w
    $error("aes128_iter_core: CNT_W must hold 0..10");
  end

  aes_state_e       fsm, fsm_next;
  block_t           state_reg, key_reg;
  logic [CNT_W-1:0] rnd;
  logic             accept;
  logic             last_step;
  block_t           chain_state, chain_key;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_stage
    block_t           s_in, k_in, s_out, k_out;
    logic [CNT_W-1:0] stage_rnd;

    if (gi == 0) begin : g_head
      assign s_in = state_reg;
      assign k_in = key_reg;
    end else begin : g_link
      assign s_in = g_stage[gi-1].s_out;
      assign k_in = g_stage[gi-1].k_out;
    end

    assign stage_rnd = rnd + CNT_W'(gi);

    aes_round_stage #(
      .CNT_W (CNT_W)
    ) u_round (
      .state      (s_in),
      .key_in     (k_in),
      .round      (stage_rnd),
      .is_last    (stage_rnd == CNT_W'(AES_ROUNDS)),
      .next_state (s_out),
      .next_key   (k_out)
    );
  end

  assign chain_state = g_stage[UNROLL-1].s_out;
  assign chain_key   = g_stage[UNROLL-1].k_out;
  assign last_step   = (rnd + CNT_W'(UNROLL - 1)) == CNT_W'(AES_ROUNDS);

  always_comb begin
    fsm_next = fsm;
    in_ready = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = RUN;
      end
      RUN: begin
        if (last_step) fsm_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) fsm_next = in_valid ? RUN : IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == RUN);

  // rnd is held on the final step so it never passes AES_ROUNDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= IDLE;
      state_reg    <= '0;
      key_reg      <= '0;
      rnd          <= '0;
      out_text     <= '0;
      out_last_key <= '0;
    end else begin
      fsm <= fsm_next;
      if (accept) begin
        state_reg <= in_text ^ in_key;
        key_reg   <= in_key;
        rnd       <= CNT_W'(1);
      end else if (fsm == RUN) begin
        state_reg <= chain_state;
        key_reg   <= chain_key;
        if (last_step) begin
          out_text     <= chain_state;
          out_last_key <= chain_key;
        end else begin
          rnd <= rnd + CNT_W'(UNROLL);
        end
      end
    end
  end

  a_rnd_range: assert property (@(posedge clk) disable iff (!rst_n) rnd <= CNT_W'(AES_ROUNDS));

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: four instances (UNROLL 1/2/5/10) checked every
// cycle against a transaction-level AES reference model plus FIPS-197 vectors.
module tb_aes128_iter_core;

  localparam int NI = 4;

  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LK_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic         in_valid [NI];
  logic         in_ready [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic         busy [NI];
  logic [127:0] in_text [NI];
  logic [127:0] in_key [NI];
  logic [127:0] out_text [NI];
  logic [127:0] out_last_key [NI];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_iter_core #(
      .UNROLL (U),
      .CNT_W  (4)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_text      (in_text[g]),
      .in_key       (in_key[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_text     (out_text[g]),
      .out_last_key (out_last_key[g]),
      .busy         (busy[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Generator walk: p steps through powers of 3, q through powers of 3^-1.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_tab[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endtask

  function automatic void aes_ref(input logic [127:0] key, input logic [127:0] pt,
                                  output logic [127:0] ct, output logic [127:0] lk);
    logic [7:0] w [44][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, x;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_tab[tmp[1]] ^ rc;
        tmp[1] = sbox_tab[tmp[2]];
        tmp[2] = sbox_tab[tmp[3]];
        tmp[3] = sbox_tab[x];
        rc     = mul2(rc);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][i%4];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) tmp[rr] = s[4*c+rr];
          for (int rr = 0; rr < 4; rr++)
            s[4*c+rr] = mul2(tmp[rr]) ^ mul2(tmp[(rr+1)%4]) ^ tmp[(rr+1)%4] ^
                        tmp[(rr+2)%4] ^ tmp[(rr+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][i%4];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    for (int i = 0; i < 16; i++) lk[127-8*i -: 8] = w[40 + i/4][i%4];
  endfunction

  function automatic int lat_of(input int u);
    int un;
    un = (u == 0) ? 1 : (u == 1) ? 2 : (u == 2) ? 5 : 10;
    return 1 + 10 / un;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic         pv [NI];
  logic [127:0] pt_e [NI];
  logic [127:0] pk_e [NI];
  logic [127:0] ht [NI];
  logic [127:0] hk [NI];
  int           due [NI];
  int           results [NI];

  initial for (int u = 0; u < NI; u++) begin
    pv[u] = 1'b0; ht[u] = '0; hk[u] = '0; due[u] = 0; results[u] = 0;
  end

  always @(negedge clk) begin
    for (int u = 0; u < NI; u++) begin
      logic ev, er;
      logic [127:0] c_ct, c_lk;
      if (!rst_n) begin
        pv[u] = 1'b0;
        ht[u] = '0;
        hk[u] = '0;
        chk($sformatf("u%0d_rst_valid", u), out_valid[u], 1'b0);
        chk($sformatf("u%0d_rst_busy", u), busy[u], 1'b0);
        chk($sformatf("u%0d_rst_ready", u), in_ready[u], 1'b1);
        chk($sformatf("u%0d_rst_text", u), out_text[u], '0);
        chk($sformatf("u%0d_rst_key", u), out_last_key[u], '0);
      end else begin
        ev = pv[u] && (cyc >= due[u]);
        if (ev) begin
          ht[u] = pt_e[u];
          hk[u] = pk_e[u];
        end
        er = !pv[u] || (ev && out_ready[u]);
        chk($sformatf("u%0d_out_valid", u), out_valid[u], ev);
        chk($sformatf("u%0d_busy", u), busy[u], pv[u] && (cyc < due[u]));
        chk($sformatf("u%0d_in_ready", u), in_ready[u], er);
        chk($sformatf("u%0d_out_text", u), out_text[u], ht[u]);
        chk($sformatf("u%0d_out_last_key", u), out_last_key[u], hk[u]);
        if (ev && out_ready[u]) begin
          pv[u] = 1'b0;
          results[u]++;
        end
        if (in_valid[u] && er) begin
          aes_ref(in_key[u], in_text[u], c_ct, c_lk);
          pt_e[u] = c_ct;
          pk_e[u] = c_lk;
          due[u]  = cyc + lat_of(u);
          pv[u]   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int u);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready[u]) ok = 1'b1;
    end
    if (!ok) chk($sformatf("u%0d_ready_timeout", u), 1'b0, 1'b1);
  endtask

  task automatic send(input int u, input logic [127:0] k, input logic [127:0] p, output int acc);
    in_key[u]   = k;
    in_text[u]  = p;
    in_valid[u] = 1'b1;
    wait_ready(u);
    step();
    acc = cyc;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, input int acc, output int lat);
    lat = -1;
    for (int n = 0; n < 200 && lat < 0; n++) begin
      @(negedge clk);
      if (out_valid[u]) lat = cyc - acc + 1;
    end
    if (lat < 0) chk($sformatf("u%0d_valid_timeout", u), 1'b0, 1'b1);
  endtask

  task automatic run_vec(input int u, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] ect, input logic [127:0] elk,
                         input int elat, input string nm);
    int acc, lat;
    send(u, k, p, acc);
    wait_valid(u, acc, lat);
    chk({nm, "_latency"}, 128'(lat), 128'(elat));
    chk({nm, "_text"}, out_text[u], ect);
    chk({nm, "_last_key"}, out_last_key[u], elk);
    step();
  endtask

  initial begin
    int acc, lat, base;
    int accs [8];
    logic [127:0] m_ct, m_lk;
    logic [7:0] sb_probe;
    bit ok;

    for (int u = 0; u < NI; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b1; in_text[u] = '0; in_key[u] = '0;
    end
    build_sbox();

    // Pin the reference model to known constants.
    sb_probe = sbox_tab[8'h00]; chk("model_sbox_00", 128'(sb_probe), 128'h63);
    sb_probe = sbox_tab[8'h01]; chk("model_sbox_01", 128'(sb_probe), 128'h7c);
    sb_probe = sbox_tab[8'h53]; chk("model_sbox_53", 128'(sb_probe), 128'hed);
    aes_ref(KB, PB, m_ct, m_lk);
    chk("model_appb_text", m_ct, CT_B);
    chk("model_appb_key", m_lk, LK_B);
    aes_ref(KC, PC, m_ct, m_lk);
    chk("model_appc_text", m_ct, CT_C);
    chk("model_appc_key", m_lk, LK_C);

    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", in_ready[0], 1'b1);
    chk("post_reset_valid", out_valid[0], 1'b0);
    chk("post_reset_text", out_text[0], '0);
    step();

    run_vec(0, KB, PB, CT_B, LK_B, 11, "u1_appb");
    run_vec(0, KC, PC, CT_C, LK_C, 11, "u1_appc");
    run_vec(1, KC, PC, CT_C, LK_C, 6, "u2_appc");
    run_vec(2, KC, PC, CT_C, LK_C, 3, "u5_appc");
    run_vec(3, KC, PC, CT_C, LK_C, 2, "u10_appc");
    run_vec(3, KB, PB, CT_B, LK_B, 2, "u10_appb");

    // Backpressure, then output handshake and new accept in the same cycle.
    out_ready[0] = 1'b0;
    send(0, KB, PB, acc);
    wait_valid(0, acc, lat);
    chk("bp_latency", 128'(lat), 128'd11);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("bp_text", out_text[0], CT_B);
      chk("bp_in_ready", in_ready[0], 1'b0);
      chk("bp_busy", busy[0], 1'b0);
      chk("bp_valid", out_valid[0], 1'b1);
    end
    step();
    in_key[0] = KC; in_text[0] = PC; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_ready", in_ready[0], 1'b1);
    step();
    acc = cyc;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_valid_dropped", out_valid[0], 1'b0);
    wait_valid(0, acc, lat);
    chk("bp_next_latency", 128'(lat), 128'd11);
    chk("bp_next_text", out_text[0], CT_C);
    step();

    // Back-to-back stream of 8 blocks.
    base = results[0];
    for (int b = 0; b < 8; b++) begin
      in_key[0]   = KB ^ {16{8'(b * 37)}};
      in_text[0]  = PB + 128'(b);
      in_valid[0] = 1'b1;
      wait_ready(0);
      step();
      accs[b] = cyc;
    end
    in_valid[0] = 1'b0;
    for (int b = 1; b < 8; b++)
      chk($sformatf("stream_interval_%0d", b), 128'(accs[b] - accs[b-1]), 128'd11);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (results[0] == base + 8) ok = 1'b1;
    end
    chk("stream_count", 128'(results[0] - base), 128'd8);
    step();

    // Reset in the middle of a block.
    send(0, KB, PB, acc);
    repeat (5) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid[0], 1'b0);
    chk("midrst_text", out_text[0], '0);
    chk("midrst_key", out_last_key[0], '0);
    chk("midrst_ready", in_ready[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    step();
    run_vec(0, KB, PB, CT_B, LK_B, 11, "midrst_appb");

    // Inputs wiggling during RUN must not disturb the captured block.
    send(0, KC, PC, acc);
    for (int n = 0; n < 6; n++) begin
      in_text[0] = {4{$urandom}};
      in_key[0]  = {4{$urandom}};
      step();
    end
    wait_valid(0, acc, lat);
    chk("stable_latency", 128'(lat), 128'd11);
    chk("stable_text", out_text[0], CT_C);
    chk("stable_key", out_last_key[0], LK_C);
    step();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
